apb2axi_write_resp_handler: RTL
===============================

APB2AXI_WRITE_RESP_HANDLER -- requirements
Module: apb2axi_write_resp_handler

Interface
REQ-001 SHALL have parameter TAG_NUM, default 8: number of tracked write tags, power of two, 2..16.
REQ-002 SHALL have parameter AXI_ID_W, default 4: AXI ID width, >= log2(TAG_NUM).
REQ-003 SHALL have parameter TO_CYC, default 1024: outstanding timeout in aclk cycles, >= 4.
REQ-004 SHALL define TAG_W = log2(TAG_NUM) and CNT_W = log2(TAG_NUM+1).
REQ-005 aclk  in  1  clock; all logic on rising edge.
REQ-006 aresetn  in  1  reset, synchronous, active-low.
REQ-007 awvalid, awready  in  1 each  snooped AW handshake from the write builder and slave.
REQ-008 awid  in  AXI_ID_W  snooped AW ID.
REQ-009 bid  in  AXI_ID_W; bresp  in  2; bvalid  in  1  AXI B channel.
REQ-010 bready  out  1  B channel accept.
REQ-011 cpl_push_vld  out  1; cpl_push_rdy  in  1  completion FIFO push handshake.
REQ-012 cpl_push_data  out  TAG_W+3  {tag[TAG_W-1:0], resp[1:0], timeout}, MSB first.
REQ-013 outstanding_cnt  out  CNT_W  number of tags awaiting B.
REQ-014 idle  out  1  high when no tag is outstanding and no completion is held.
REQ-015 err_dup_aw, err_unexp_b  out  1 each  single-cycle error pulses.

Function
REQ-016 SHALL count an AW fire (awvalid&&awready) with awid < TAG_NUM and tag not outstanding: set outstanding[awid], clear timer[awid]; visible next cycle.
REQ-017 SHALL pulse err_dup_aw for one cycle on an AW fire whose tag is already outstanding or whose awid >= TAG_NUM, leaving tag state unchanged.
REQ-018 SHALL hold one completion register (cpl_vld, payload); cpl_push_vld = cpl_vld; payload stable while cpl_push_vld && !cpl_push_rdy.
REQ-019 SHALL drive bready = !cpl_vld || cpl_push_rdy (combinational through cpl_push_rdy).
REQ-020 SHALL, on B fire with bid outstanding, clear outstanding[bid] and load {bid, bresp, 0}; cpl_push_vld asserts the next cycle (latency 1).
REQ-021 SHALL, on B fire with bid not outstanding or bid >= TAG_NUM, pulse err_unexp_b next cycle, load no completion, and still accept the beat.
REQ-022 SHALL judge B and AW legality against pre-cycle state; same-cycle B clear and AW set on one tag leaves it outstanding with timer cleared.
REQ-023 SHALL increment timer[t] each cycle outstanding[t] is high; at TO_CYC-1 set to_pend[t] and clear outstanding[t].
REQ-024 SHALL load a timeout completion {t, 2'b10, 1} for the lowest to_pend tag only when the register is free or popping and no B fire occurs that cycle; B has priority.
REQ-025 SHALL clear to_pend[t] when its completion loads; a later B for t is treated as unexpected (REQ-021).
REQ-026 SHALL count a tag in outstanding_cnt while outstanding or to_pend, registered, updating the cycle after each event.
REQ-027 SHALL use saturating-free timers of width log2(TO_CYC); no wrap occurs before timeout.

Reset
REQ-028 SHALL, while aresetn is low, clear outstanding, to_pend, all timers, cpl_vld and payload; outputs: bready=1, cpl_push_vld=0, cpl_push_data=0, outstanding_cnt=0, idle=1, errors=0.
REQ-029 SHALL discard in-flight tracking on reset mid-operation; B responses after reset are unexpected.

Verification
REQ-030 AW id=3, 5 cycles later B id=3 bresp=0, cpl_push_rdy=1 -> cpl_push_vld one cycle after B fire, data {3,00,0}; outstanding_cnt 1 -> 0; idle=1.
REQ-031 AW ids 1,2,4; cpl_push_rdy=0; B id=2 then bvalid id=4 -> first accepted, bready=0 for id 4 until rdy=1; pops {2,..} then {4,..} in order, no loss.
REQ-032 B id=6 with nothing outstanding -> err_unexp_b one-cycle pulse, bready=1, no cpl_push_vld, outstanding_cnt unchanged.
REQ-033 AW id=0 then AW id=0 again before B -> err_dup_aw pulse on second, outstanding_cnt stays 1.
REQ-034 TO_CYC=16, AW id=5, no B -> cpl {5,10,1} pushed 16-17 cycles later; subsequent B id=5 -> err_unexp_b.
REQ-035 AW ids 1,2 then aresetn low 1 cycle -> outstanding_cnt=0, idle=1; B id=1 afterwards -> err_unexp_b.

Source files
------------

// File: rtl/apb2axi_write_resp_handler.sv
// apb2axi_write_resp_handler
//
// Tracks AXI write tags between the AW handshake and the matching B
// response. Each tag is forwarded to a completion FIFO exactly once, either
// with the real B response or with a synthesized SLVERR timeout entry.
// Protocol violations are flagged with one-cycle error pulses.
//
// Ports
//   aclk, aresetn              clock, synchronous active-low reset
//   awvalid, awready, awid     snooped AW handshake
//   bvalid, bid, bresp, bready AXI B channel (bready driven here)
//   cpl_push_vld/rdy/data      completion FIFO push, data = {tag, resp, timeout}
//   outstanding_cnt            tags still awaiting B or a timeout completion
//   idle                       nothing tracked and no completion held
//   err_dup_aw, err_unexp_b    one-cycle error pulses

module apb2axi_write_resp_handler #(
  parameter int TAG_NUM  = 8,
  parameter int AXI_ID_W = 4,
  parameter int TO_CYC   = 1024,
  parameter int TAG_W    = $clog2(TAG_NUM),
  parameter int CNT_W    = $clog2(TAG_NUM + 1)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                awvalid,
  input  logic                awready,
  input  logic [AXI_ID_W-1:0] awid,
  input  logic [AXI_ID_W-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                cpl_push_vld,
  input  logic                cpl_push_rdy,
  output logic [TAG_W+2:0]    cpl_push_data,
  output logic [CNT_W-1:0]    outstanding_cnt,
  output logic                idle,
  output logic                err_dup_aw,
  output logic                err_unexp_b
);

  localparam int TMR_W = $clog2(TO_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TO_CYC - 1);

  logic [TAG_NUM-1:0] out_q, out_n;
  logic [TAG_NUM-1:0] pend_q, pend_n;
  logic [TMR_W-1:0]   timer_q [TAG_NUM];
  logic [TMR_W-1:0]   timer_n [TAG_NUM];
  logic               cpl_vld_q, cpl_vld_n;
  logic [TAG_W+2:0]   cpl_data_q, cpl_data_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               dup_q, dup_n;
  logic               unexp_q, unexp_n;

  logic               cpl_free;
  logic               aw_fire, b_fire;
  logic               aw_in_range, b_in_range;
  logic [TAG_W-1:0]   aw_tag, b_tag, to_idx;
  logic               aw_ok, b_hit, to_load;
  logic [TAG_NUM-1:0] aw_set, b_clr, pend_clr, occ_n;

  // The completion register can take a new entry when empty or popping this
  // cycle, so B is accepted on exactly those cycles.
  assign cpl_free = !cpl_vld_q || cpl_push_rdy;
  assign bready   = cpl_free;
  assign aw_fire  = awvalid && awready;
  assign b_fire   = bvalid && cpl_free;

  // IDs wider than the tag space are legal only when the upper bits are zero.
  assign aw_in_range = (awid >> TAG_W) == '0;
  assign b_in_range  = (bid >> TAG_W) == '0;
  assign aw_tag      = awid[TAG_W-1:0];
  assign b_tag       = bid[TAG_W-1:0];

  // Legality is judged against the registered state only.
  assign aw_ok = aw_fire && aw_in_range && !out_q[aw_tag];
  assign b_hit = b_fire && b_in_range && out_q[b_tag];

  // Next-state computation: tag tracking, timers, completion register.
  always_comb begin
    out_n      = out_q;
    pend_n     = pend_q;
    timer_n    = timer_q;
    cpl_vld_n  = cpl_vld_q;
    cpl_data_n = cpl_data_q;
    aw_set     = '0;
    b_clr      = '0;
    pend_clr   = '0;
    to_idx     = '0;
    cnt_n      = '0;

    if (aw_ok) aw_set[aw_tag] = 1'b1;
    if (b_hit) b_clr[b_tag]   = 1'b1;

    // Lowest-numbered pending timeout wins; the loop runs high to low.
    for (int i = TAG_NUM - 1; i >= 0; i--) begin
      if (pend_q[i]) to_idx = TAG_W'(i);
    end
    to_load = cpl_free && !b_fire && (pend_q != '0);
    if (to_load) pend_clr[to_idx] = 1'b1;

    // Clears are applied before sets so a fresh timeout or AW on the same
    // tag in the same cycle survives.
    for (int i = 0; i < TAG_NUM; i++) begin
      if (pend_clr[i]) pend_n[i] = 1'b0;
      if (b_clr[i]) begin
        out_n[i] = 1'b0;
      end else if (out_q[i]) begin
        if (timer_q[i] == TMR_LAST) begin
          out_n[i]  = 1'b0;
          pend_n[i] = 1'b1;
        end else begin
          timer_n[i] = timer_q[i] + TMR_W'(1);
        end
      end
      if (aw_set[i]) begin
        out_n[i]   = 1'b1;
        timer_n[i] = '0;
      end
    end

    // A real B response takes priority over a synthesized timeout.
    if (b_hit) begin
      cpl_vld_n  = 1'b1;
      cpl_data_n = {b_tag, bresp, 1'b0};
    end else if (to_load) begin
      cpl_vld_n  = 1'b1;
      cpl_data_n = {to_idx, 2'b10, 1'b1};
    end else if (cpl_push_rdy) begin
      cpl_vld_n  = 1'b0;
    end

    occ_n = out_n | pend_n;
    for (int i = 0; i < TAG_NUM; i++) begin
      cnt_n = cnt_n + CNT_W'(occ_n[i]);
    end

    dup_n   = aw_fire && !aw_ok;
    unexp_n = b_fire && !b_hit;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_q      <= '0;
      pend_q     <= '0;
      cpl_vld_q  <= 1'b0;
      cpl_data_q <= '0;
      cnt_q      <= '0;
      dup_q      <= 1'b0;
      unexp_q    <= 1'b0;
      for (int i = 0; i < TAG_NUM; i++) timer_q[i] <= '0;
    end else begin
      out_q      <= out_n;
      pend_q     <= pend_n;
      cpl_vld_q  <= cpl_vld_n;
      cpl_data_q <= cpl_data_n;
      cnt_q      <= cnt_n;
      dup_q      <= dup_n;
      unexp_q    <= unexp_n;
      for (int i = 0; i < TAG_NUM; i++) timer_q[i] <= timer_n[i];
    end
  end

  assign cpl_push_vld    = cpl_vld_q;
  assign cpl_push_data   = cpl_data_q;
  assign outstanding_cnt = cnt_q;
  assign idle            = (cnt_q == '0) && !cpl_vld_q;
  assign err_dup_aw      = dup_q;
  assign err_unexp_b     = unexp_q;

endmodule
